pc_call_ctrl: RTL

Program-counter and call/return sequencer that sits directly upstream of the return-address stack. Each cycle it decodes a control op and updates the PC. On CALL it drives the stack with the return address (PC+1) and a push. On RET it reloads the PC from the stack's peek value and issues a pop. It keeps its own call-depth count because the stack exposes no full/empty flags.

---
 rtl/pc_ctrl_pkg.sv | 17 +
 rtl/call_depth_tracker.sv | 39 +++
 rtl/pc_call_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared opcode and state definitions for the PC / call-return sequencer.
package pc_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_NEXT = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/call_depth_tracker.sv
// Saturating count of live return addresses, 0..2**depth, with full/empty flags.
module call_depth_tracker #(
  parameter int depth = 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           inc,
  input  logic           dec,
  output logic [depth:0] count,
  output logic           at_full,
  output logic           at_empty
);

  localparam logic [depth:0] CAP = {1'b1, {depth{1'b0}}};

  logic [depth:0] count_q, count_d;

  assign at_full  = (count_q == CAP);
  assign at_empty = (count_q == '0);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !at_full) begin
      count_d = count_q + (depth+1)'(1);
    end else if (dec && !inc && !at_empty) begin
      count_d = count_q - (depth+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pc_call_ctrl.sv
// Program counter and call/return sequencer driving a return-address stack.
// Optional overflow/underflow trap: define PC_STACK_GUARD_EN.
module pc_call_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int               width    = 8,
  parameter int               depth    = 1,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [width-1:0] target,
  input  logic             cond,
  input  logic             stall,
  output logic [width-1:0] pc,
  output logic             running,
  output logic             fault,
  output logic [depth:0]   call_depth,
  output logic [width-1:0] stk_push,
  output logic             stk_c,
  output logic             stk_en,
  input  logic [width-1:0] stk_peek
);

  state_e           state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] pc_inc;
  logic             en_d, c_d;
  logic             inc, dec;
  logic             at_full, at_empty;

  call_depth_tracker #(
    .depth(depth)
  ) u_depth (
    .clk      (clk),
    .clr      (clr),
    .inc      (inc),
    .dec      (dec),
    .count    (call_depth),
    .at_full  (at_full),
    .at_empty (at_empty)
  );

  assign pc_inc   = pc_q + width'(1);
  assign pc       = pc_q;
  assign stk_push = pc_inc;
  assign running  = (state_q == ST_RUN);
`ifdef PC_STACK_GUARD_EN
  assign fault    = (state_q == ST_FAULT);
`else
  assign fault    = 1'b0;
`endif

  // Stack strobes are gated by clr so nothing reaches the stack during reset.
  assign stk_en = en_d & clr;
  assign stk_c  = c_d & clr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    en_d    = 1'b0;
    c_d     = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          case (op)
            OP_NOP:  pc_d = pc_q;
            OP_NEXT: pc_d = pc_inc;
            OP_JMP:  pc_d = target;
            OP_BR:   pc_d = cond ? target : pc_inc;
            OP_CALL: begin
`ifdef PC_STACK_GUARD_EN
              if (at_full) begin
                state_d = ST_FAULT;
              end else begin
                en_d = 1'b1;
                c_d  = 1'b1;
                pc_d = target;
                inc  = 1'b1;
              end
`else
              en_d = 1'b1;
              c_d  = 1'b1;
              pc_d = target;
              inc  = !at_full;
`endif
            end
            OP_RET: begin
`ifdef PC_STACK_GUARD_EN
              if (at_empty) begin
                state_d = ST_FAULT;
              end else begin
                en_d = 1'b1;
                pc_d = stk_peek;
                dec  = 1'b1;
              end
`else
              en_d = 1'b1;
              pc_d = stk_peek;
              dec  = !at_empty;
`endif
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule
